uart_echo_tester: RTL and testbench

//   Initiator end of the UART echo link: drives the uart core TX with a PRBS byte stream, waits for each

---
 rtl/uart_echo_tester_pkg.sv | 32 +++
 rtl/uart_echo_tester_prbs8.sv | 42 ++++
 rtl/uart_echo_tester.sv | 212 +++++++++++++++++++++
 tb/tb_uart_echo_tester.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_test_pkg
// Brief    : Shared FSM encoding, LFSR taps and timeout helpers for the echo tester.
// Revision : 1.0
// ============================================================================
package uart_test_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_TX   = 3'd2;
    localparam logic [2:0] ST_WAIT_ECHO = 3'd3;
    localparam logic [2:0] ST_NEXT      = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // Feedback taps at bits 7,5,4,3
    localparam logic [7:0] C_LFSR_TAPS = 8'hB8;

    // Four frame times of 10 bits each
    function automatic int unsigned default_timeout(input longint unsigned clk_hz,
                                                    input longint unsigned baud);
        longint unsigned t;
        t = (64'd40 * clk_hz) / baud;
        return t[31:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_echo_tester_prbs8.sv
`default_nettype none
// ============================================================================
// Module   : prbs8
// Brief    : 8-bit Fibonacci LFSR byte source with synchronous load and advance.
// Revision : 1.0
// ============================================================================
module prbs8
    import uart_test_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       adv_i,
    output logic [7:0] q_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (adv_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & C_LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/uart_echo_tester.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_tester
// Brief    : Sends a PRBS byte stream through a UART core and checks each echo.
// Revision : 1.0
// ============================================================================
module uart_echo_tester
    import uart_test_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned BAUD           = 115200,
    parameter int unsigned NUM_BYTES      = 16,
    parameter logic [7:0]  SEED           = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES = default_timeout(CLK_FREQ_HZ, BAUD)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_ferr,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] tx_count,
    output logic        timeout_seen,
    output logic [7:0]  last_exp,
    output logic [7:0]  last_got
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          done_q, done_d;
    logic [15:0]   err_q, err_d;
    logic [15:0]   txc_q, txc_d;
    logic          tmo_q, tmo_d;
    logic [7:0]    exp_q, exp_d;
    logic [7:0]    got_q, got_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          seen_busy_q, seen_busy_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_data_q, pend_data_d;
    logic          pend_ferr_q, pend_ferr_d;

    logic          w_busy;
    logic          w_echo;
    logic [7:0]    w_echo_byte;
    logic          w_echo_ferr;
    logic          w_lfsr_load;
    logic          w_lfsr_adv;
    logic [7:0]    w_lfsr;

    prbs8 #(
        .SEED (SEED)
    ) u_prbs8 (
        .clk    (clk),
        .rst    (rst),
        .load_i (w_lfsr_load),
        .adv_i  (w_lfsr_adv),
        .q_o    (w_lfsr)
    );

    assign w_busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    // An echo captured during WAIT_TX takes precedence over a live one
    assign w_echo      = pend_q || rx_valid;
    assign w_echo_byte = pend_q ? pend_data_q : rx_data;
    assign w_echo_ferr = pend_q ? pend_ferr_q : rx_ferr;

    always_comb begin
        state_d     = state_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        done_d      = done_q;
        err_d       = err_q;
        txc_d       = txc_q;
        tmo_d       = tmo_q;
        exp_d       = exp_q;
        got_d       = got_q;
        timer_d     = timer_q;
        seen_busy_d = seen_busy_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        pend_ferr_d = pend_ferr_q;
        w_lfsr_load = 1'b0;
        w_lfsr_adv  = 1'b0;

        if (w_busy && abort) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = ST_SEND;
                        done_d      = 1'b0;
                        err_d       = 16'd0;
                        txc_d       = 16'd0;
                        tmo_d       = 1'b0;
                        pend_d      = 1'b0;
                        w_lfsr_load = 1'b1;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data_d   = w_lfsr;
                        tx_start_d  = 1'b1;
                        txc_d       = sat_inc16(txc_q);
                        seen_busy_d = 1'b0;
                        state_d     = ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (rx_valid) begin
                        pend_d      = 1'b1;
                        pend_data_d = rx_data;
                        pend_ferr_d = rx_ferr;
                    end
                    if (tx_busy) begin
                        seen_busy_d = 1'b1;
                    end else if (seen_busy_q) begin
                        timer_d = '0;
                        state_d = ST_WAIT_ECHO;
                    end
                end
                ST_WAIT_ECHO: begin
                    timer_d = timer_q + 1'b1;
                    if (w_echo) begin
                        exp_d   = tx_data_q;
                        got_d   = w_echo_byte;
                        pend_d  = 1'b0;
                        state_d = ST_NEXT;
                        if (w_echo_ferr || (w_echo_byte != tx_data_q)) begin
                            err_d = sat_inc16(err_q);
                        end
                    end else if (timer_q == C_TMO_LAST) begin
                        err_d   = sat_inc16(err_q);
                        tmo_d   = 1'b1;
                        got_d   = 8'h00;
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    w_lfsr_adv = 1'b1;
                    if ((NUM_BYTES != 0) && (txc_q == 16'(NUM_BYTES))) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 16'd0;
            txc_q       <= 16'd0;
            tmo_q       <= 1'b0;
            exp_q       <= 8'h00;
            got_q       <= 8'h00;
            timer_q     <= '0;
            seen_busy_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
            pend_ferr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            txc_q       <= txc_d;
            tmo_q       <= tmo_d;
            exp_q       <= exp_d;
            got_q       <= got_d;
            timer_q     <= timer_d;
            seen_busy_q <= seen_busy_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            pend_ferr_q <= pend_ferr_d;
        end
    end

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign busy         = w_busy;
    assign done         = done_q;
    assign pass         = done_q && (err_q == 16'd0) && (txc_q != 16'd0);
    assign err_count    = err_q;
    assign tx_count     = txc_q;
    assign timeout_seen = tmo_q;
    assign last_exp     = exp_q;
    assign last_got     = got_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_echo_tester
// Brief    : Directed bench: fast UART core + echo responder model around the tester.
// Revision : 1.0
// ============================================================================
module tb_uart_echo_tester;

    localparam int TMO   = 34722;
    localparam int TXLEN = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic sel = 1'b0;
    logic tx_busy = 1'b0, rx_valid = 1'b0, rx_ferr = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic txs_a, busy_a, done_a, pass_a, tmo_a;
    logic [7:0] txd_a, exp_a, got_a;
    logic [15:0] err_a, txc_a;
    logic txs_b, busy_b, done_b, pass_b, tmo_b;
    logic [7:0] txd_b, exp_b, got_b;
    logic [15:0] err_b, txc_b;

    uart_echo_tester #(.NUM_BYTES(4), .SEED(8'h01)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .tx_start(txs_a), .tx_data(txd_a), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .tx_count(txc_a), .timeout_seen(tmo_a), .last_exp(exp_a), .last_got(got_a)
    );

    uart_echo_tester #(.NUM_BYTES(0), .SEED(8'h01)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .tx_start(txs_b), .tx_data(txd_b), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .tx_count(txc_b), .timeout_seen(tmo_b), .last_exp(exp_b), .last_got(got_b)
    );

    // Core + responder model: busy for TXLEN cycles per frame, echo TXLEN+echo_off after start
    logic m_txs;
    logic [7:0] m_txd;
    assign m_txs = sel ? txs_b : txs_a;
    assign m_txd = sel ? txd_b : txd_a;

    int m_cnt = 0, m_ecnt = -1, m_idx = 0, m_echoes = 0;
    int base = 0, flip_rel = -1, drop_rel = -1, ferr_rel = -1, echo_off = 3;
    logic [7:0] m_edata = 8'h00;
    logic m_eferr = 1'b0;
    logic [7:0] sent [0:255];

    always @(posedge clk) begin
        rx_valid <= 1'b0;
        rx_ferr  <= 1'b0;
        if (rst) begin
            tx_busy <= 1'b0;
            m_cnt   <= 0;
            m_ecnt  <= -1;
        end else begin
            if (m_ecnt > 0) begin
                m_ecnt <= m_ecnt - 1;
            end else if (m_ecnt == 0) begin
                rx_valid <= 1'b1;
                rx_data  <= m_edata;
                rx_ferr  <= m_eferr;
                m_ecnt   <= -1;
                m_echoes <= m_echoes + 1;
            end
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) tx_busy <= 1'b0;
            end else if (m_txs) begin
                tx_busy <= 1'b1;
                m_cnt   <= TXLEN;
                if (m_idx < 256) sent[m_idx] <= m_txd;
                m_idx   <= m_idx + 1;
                m_edata <= m_txd ^ (((m_idx - base) == flip_rel) ? 8'h01 : 8'h00);
                m_eferr <= ((m_idx - base) == ferr_rel);
                if ((m_idx - base) != drop_rel) m_ecnt <= TXLEN + echo_off;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({txs_a, txd_a, busy_a, done_a, pass_a, tmo_a} !== 13'd0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 0", {txs_a, txd_a, busy_a, done_a, pass_a, tmo_a});
        end
        checks++;
        if ({err_a, txc_a, exp_a, got_a} !== 48'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h want 0", {err_a, txc_a, exp_a, got_a});
        end
    endtask

    task automatic test_clean();
        logic [7:0] want [4];
        bit ok;
        want = '{8'h01, 8'h02, 8'h04, 8'h08};
        base = m_idx; flip_rel = -1; drop_rel = -1; ferr_rel = -1; echo_off = 3;
        pulse_start_a();
        wait_done_a(2000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clean_done: got timeout want done"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sent[base + i] !== want[i]) begin
                errors++;
                $display("FAIL clean_byte%0d: got %h want %h", i, sent[base + i], want[i]);
            end
        end
        checks++;
        if ({pass_a, busy_a, tmo_a, err_a, txc_a} !== {1'b1, 1'b0, 1'b0, 16'd0, 16'd4}) begin
            errors++;
            $display("FAIL clean_status: pass=%b busy=%b tmo=%b err=%0d txc=%0d want 1 0 0 0 4",
                     pass_a, busy_a, tmo_a, err_a, txc_a);
        end
        checks++;
        if ({exp_a, got_a} !== 16'h0808) begin
            errors++;
            $display("FAIL clean_last: got %h want 0808", {exp_a, got_a});
        end
    endtask

    task automatic test_flip();
        bit ok;
        int n;
        base = m_idx; flip_rel = 2; drop_rel = -1; ferr_rel = -1; echo_off = -4;
        pulse_start_a();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL flip_restart: done=%b busy=%b want 0 1", done_a, busy_a);
        end
        n = 0;
        while (err_a == 16'd0 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if ({exp_a, got_a} !== 16'h0405) begin
            errors++;
            $display("FAIL flip_compare: got %h want 0405", {exp_a, got_a});
        end
        wait_done_a(2000, ok);
        checks++;
        if (!ok || err_a !== 16'd1 || pass_a !== 1'b0 || txc_a !== 16'd4) begin
            errors++;
            $display("FAIL flip_final: done=%b err=%0d pass=%b txc=%0d want 1 1 0 4", ok, err_a, pass_a, txc_a);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        base = m_idx; flip_rel = -1; drop_rel = 1; ferr_rel = -1; echo_off = 3;
        pulse_start_a();
        n = 0;
        while ((m_idx - base) < 2 && n < 2000) begin @(negedge clk); n++; end
        while (tx_busy && n < 4000) begin @(negedge clk); n++; end
        n = 0;
        while (!tmo_a && n < TMO + 100) begin @(negedge clk); n++; end
        checks++;
        if (n !== TMO + 1) begin
            errors++;
            $display("FAIL tmo_latency: got %0d want %0d", n, TMO + 1);
        end
        checks++;
        if (got_a !== 8'h00 || err_a !== 16'd1) begin
            errors++;
            $display("FAIL tmo_event: got_a=%h err=%0d want 00 1", got_a, err_a);
        end
        wait_done_a(2000, ok);
        checks++;
        if (!ok || txc_a !== 16'd4 || tmo_a !== 1'b1 || err_a !== 16'd1 || pass_a !== 1'b0) begin
            errors++;
            $display("FAIL tmo_final: done=%b txc=%0d tmo=%b err=%0d pass=%b want 1 4 1 1 0",
                     ok, txc_a, tmo_a, err_a, pass_a);
        end
    endtask

    task automatic test_ferr();
        bit ok;
        base = m_idx; flip_rel = -1; drop_rel = -1; ferr_rel = 0; echo_off = 3;
        pulse_start_a();
        wait_done_a(2000, ok);
        checks++;
        if (!ok || err_a !== 16'd1 || pass_a !== 1'b0 || tmo_a !== 1'b0 || txc_a !== 16'd4) begin
            errors++;
            $display("FAIL ferr_final: done=%b err=%0d pass=%b tmo=%b txc=%0d want 1 1 0 0 4",
                     ok, err_a, pass_a, tmo_a, txc_a);
        end
    endtask

    task automatic test_abort();
        int n;
        int e0;
        sel = 1'b1;
        base = m_idx; flip_rel = -1; drop_rel = -1; ferr_rel = -1; echo_off = 3;
        e0 = m_echoes;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while ((m_echoes - e0) < 10 && n < 5000) begin @(negedge clk); n++; end
        abort_b = 1'b1;
        @(negedge clk);
        abort_b = 1'b0;
        checks++;
        if (done_b !== 1'b1 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: done=%b busy=%b want 1 0", done_b, busy_b);
        end
        checks++;
        if (txc_b < 16'd10 || txc_b > 16'd11) begin
            errors++;
            $display("FAIL abort_txc: got %0d want 10..11", txc_b);
        end
        start_b = 1'b1;
        abort_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        abort_b = 1'b0;
        checks++;
        if (busy_b !== 1'b1 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_wins: busy=%b done=%b want 1 0", busy_b, done_b);
        end
        abort_b = 1'b1;
        @(negedge clk);
        abort_b = 1'b0;
        checks++;
        if (done_b !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy_wins: done=%b want 1", done_b);
        end
        repeat (3 * TXLEN) @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_rst_mid();
        bit ok;
        int n;
        base = m_idx; flip_rel = -1; drop_rel = 0; ferr_rel = -1; echo_off = 3;
        pulse_start_a();
        n = 0;
        while (!tx_busy && n < 100) begin @(negedge clk); n++; end
        while (tx_busy && n < 200) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({txs_a, txd_a, busy_a, done_a, pass_a, tmo_a, err_a, txc_a, exp_a, got_a} !== 61'd0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b done=%b txc=%0d err=%0d txd=%h want all 0",
                     busy_a, done_a, txc_a, err_a, txd_a);
        end
        base = m_idx; drop_rel = -1;
        pulse_start_a();
        n = 0;
        while ((m_idx - base) < 2 && n < 2000) begin @(negedge clk); n++; end
        pulse_start_a();
        wait_done_a(2000, ok);
        checks++;
        if (!ok || (m_idx - base) !== 4 || sent[base + 2] !== 8'h04 || txc_a !== 16'd4 || pass_a !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: done=%b sent=%0d byte2=%h txc=%0d pass=%b want 1 4 04 4 1",
                     ok, m_idx - base, sent[base + 2], txc_a, pass_a);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_flip();
        test_timeout();
        test_ferr();
        test_abort();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(10 * 300000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
